psum_accumulator: RTL and testbench

Parametrised partial-sum accumulator for the convolution PE datapath: holds NUM_ACC independent output-pixel accumulators (generalising the fixed 2x2 c11..c22 bank), adds PE partial sums into a selected entry with optional saturation, and echoes each running sum one cycle later. A drain mode streams every finished accumulator out over a valid/ready handshake and clears it, so the next window can accumulate without a global reset.

---
 rtl/acc_pkg.sv | 17 +
 rtl/acc_sat_add.sv | 27 ++
 rtl/psum_accumulator.sv | 147 ++++++++++++++
 tb/tb_psum_accumulator.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// Shared definitions for the partial-sum accumulator.
//   state_e  : FSM states (accumulate / drain).
//   idx_w    : index width for a given accumulator count (never below 1).
//   sat_max  : all-ones clamp value for a given accumulator width.
package acc_pkg;

   typedef enum logic [0:0] {ACCUM, DRAIN} state_e;

   function automatic int unsigned idx_w(input int unsigned num);
      return (num > 1) ? $clog2(num) : 1;
   endfunction

   function automatic logic [63:0] sat_max(input int unsigned w);
      return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
   endfunction

endpackage

// File: rtl/acc_sat_add.sv
// Combinational ACC_W-bit unsigned adder with optional clamp.
//   a_i, b_i : operands
//   sum_o    : a_i + b_i, clamped to all-ones on overflow when SAT=1, else wrapped
//   ovf_o    : carry out of the ACC_W-bit add
module acc_sat_add
   import acc_pkg::*;
#(
   parameter int unsigned ACC_W = 16,
   parameter bit          SAT   = 1'b1
) (
   input  logic [ACC_W-1:0] a_i,
   input  logic [ACC_W-1:0] b_i,
   output logic [ACC_W-1:0] sum_o,
   output logic             ovf_o
);

   localparam logic [ACC_W-1:0] SatMax = ACC_W'(sat_max(ACC_W));

   logic [ACC_W:0] full;

   always_comb begin
      full  = {1'b0, a_i} + {1'b0, b_i};
      ovf_o = full[ACC_W];
      sum_o = (SAT && ovf_o) ? SatMax : full[ACC_W-1:0];
   end

endmodule

// File: rtl/psum_accumulator.sv
// Bank of NUM_ACC partial-sum accumulators with a drain stream.
//   clk, rst                  : clock, synchronous active-high reset
//   in_valid/in_ready         : input handshake (ready only while accumulating)
//   in_idx, in_first, p_sum   : target entry, load-not-add flag, partial sum
//   sum_valid, sum_out        : registered echo of the updated entry
//   drain_req, drain_busy     : start / status of the drain sweep
//   out_valid/out_ready       : drain handshake
//   out_idx, out_data         : drained entry index and value
//   sat_flag                  : sticky overflow, cleared when a drain completes
module psum_accumulator
   import acc_pkg::*;
#(
   parameter int unsigned  DATA_W  = 8,
   parameter int unsigned  ACC_W   = 16,
   parameter int unsigned  NUM_ACC = 4,
   parameter bit           SAT     = 1'b1,
   localparam int unsigned IDX_W   = idx_w(NUM_ACC)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [IDX_W-1:0]  in_idx,
   input  logic              in_first,
   input  logic [DATA_W-1:0] p_sum,
   output logic              sum_valid,
   output logic [ACC_W-1:0]  sum_out,
   input  logic              drain_req,
   output logic              drain_busy,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [IDX_W-1:0]  out_idx,
   output logic [ACC_W-1:0]  out_data,
   output logic              sat_flag
);

   localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_ACC - 1);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [ACC_W-1:0] acc_q [NUM_ACC];
   logic [ACC_W-1:0] acc_d [NUM_ACC];
   logic [ACC_W-1:0] sum_q, sum_d;
   logic             sum_valid_q, sum_valid_d;
   logic             sat_q, sat_d;

   logic [ACC_W-1:0] acc_sel, add_a, add_sum;
   logic             add_ovf, idx_ok;

   // One adder shared by all entries; a load is an add onto zero.
   always_comb begin
      acc_sel = '0;
      for (int unsigned i = 0; i < NUM_ACC; i++) begin
         if (in_idx == IDX_W'(i)) acc_sel = acc_q[i];
      end
      idx_ok = 32'(in_idx) < NUM_ACC;
      add_a  = in_first ? '0 : acc_sel;
   end

   acc_sat_add #(
      .ACC_W (ACC_W),
      .SAT   (SAT)
   ) u_add (
      .a_i   (add_a),
      .b_i   (ACC_W'(p_sum)),
      .sum_o (add_sum),
      .ovf_o (add_ovf)
   );

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      sum_d       = '0;
      sum_valid_d = 1'b0;
      sat_d       = sat_q;
      for (int unsigned i = 0; i < NUM_ACC; i++) acc_d[i] = acc_q[i];

      unique case (state_q)
         ACCUM: begin
            // An input arriving with drain_req lands before the sweep starts.
            if (in_valid && idx_ok) begin
               for (int unsigned i = 0; i < NUM_ACC; i++) begin
                  if (in_idx == IDX_W'(i)) acc_d[i] = add_sum;
               end
               sum_d       = add_sum;
               sum_valid_d = 1'b1;
               if (add_ovf) sat_d = 1'b1;
            end
            if (drain_req) begin
               state_d = DRAIN;
               ptr_d   = '0;
            end
         end
         DRAIN: begin
            if (out_ready) begin
               for (int unsigned i = 0; i < NUM_ACC; i++) begin
                  if (ptr_q == IDX_W'(i)) acc_d[i] = '0;
               end
               if (ptr_q == LastIdx) begin
                  state_d = ACCUM;
                  ptr_d   = '0;
                  sat_d   = 1'b0;
               end else begin
                  ptr_d = ptr_q + 1'b1;
               end
            end
         end
         default: state_d = ACCUM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ACCUM;
         ptr_q       <= '0;
         sum_q       <= '0;
         sum_valid_q <= 1'b0;
         sat_q       <= 1'b0;
         for (int unsigned i = 0; i < NUM_ACC; i++) acc_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         sum_q       <= sum_d;
         sum_valid_q <= sum_valid_d;
         sat_q       <= sat_d;
         for (int unsigned i = 0; i < NUM_ACC; i++) acc_q[i] <= acc_d[i];
      end
   end

   always_comb begin
      out_data = '0;
      if (state_q == DRAIN) begin
         for (int unsigned i = 0; i < NUM_ACC; i++) begin
            if (ptr_q == IDX_W'(i)) out_data = acc_q[i];
         end
      end
   end

   assign in_ready   = (state_q == ACCUM);
   assign drain_busy = (state_q == DRAIN);
   assign out_valid  = drain_busy;
   assign out_idx    = drain_busy ? ptr_q : '0;
   assign sum_out    = sum_q;
   assign sum_valid  = sum_valid_q;
   assign sat_flag   = sat_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// Drives three configurations of psum_accumulator with shared stimulus:
//   cfg0: defaults (ACC_W=16, SAT=1, NUM_ACC=4)
//   cfg1: ACC_W=8, SAT=1, NUM_ACC=4
//   cfg2: ACC_W=8, SAT=0, NUM_ACC=3
// and compares each against an arithmetic reference model.
module tb_psum_accumulator;

   logic       clk = 1'b0;
   logic       rst, in_valid, in_first, drain_req, out_ready;
   logic [1:0] in_idx;
   logic [7:0] p_sum;

   logic [2:0]  rdy, sv, busy, ov, sat;
   logic [1:0]  oidx [3];
   logic [15:0] so0, od0;
   logic [7:0]  so1, so2, od1, od2;
   logic [15:0] so [3];
   logic [15:0] od [3];

   assign so[0] = so0;
   assign so[1] = {8'd0, so1};
   assign so[2] = {8'd0, so2};
   assign od[0] = od0;
   assign od[1] = {8'd0, od1};
   assign od[2] = {8'd0, od2};

   always #5 clk = ~clk;

   psum_accumulator u_d16 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]), .in_idx(in_idx),
      .in_first(in_first), .p_sum(p_sum), .sum_valid(sv[0]), .sum_out(so0),
      .drain_req(drain_req), .drain_busy(busy[0]), .out_valid(ov[0]), .out_ready(out_ready),
      .out_idx(oidx[0]), .out_data(od0), .sat_flag(sat[0])
   );

   psum_accumulator #(.ACC_W(8), .SAT(1'b1), .NUM_ACC(4)) u_s8 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]), .in_idx(in_idx),
      .in_first(in_first), .p_sum(p_sum), .sum_valid(sv[1]), .sum_out(so1),
      .drain_req(drain_req), .drain_busy(busy[1]), .out_valid(ov[1]), .out_ready(out_ready),
      .out_idx(oidx[1]), .out_data(od1), .sat_flag(sat[1])
   );

   psum_accumulator #(.ACC_W(8), .SAT(1'b0), .NUM_ACC(3)) u_w8 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]), .in_idx(in_idx),
      .in_first(in_first), .p_sum(p_sum), .sum_valid(sv[2]), .sum_out(so2),
      .drain_req(drain_req), .drain_busy(busy[2]), .out_valid(ov[2]), .out_ready(out_ready),
      .out_idx(oidx[2]), .out_data(od2), .sat_flag(sat[2])
   );

   // Reference model: one record per configuration.
   int     cfg_aw  [3] = '{16, 8, 8};
   bit     cfg_sat [3] = '{1'b1, 1'b1, 1'b0};
   int     cfg_n   [3] = '{4, 4, 3};
   longint m_acc [3][4];
   bit     m_dr  [3];
   int     m_ptr [3];
   bit     m_sat [3];
   longint m_sum [3];
   bit     m_sv  [3];

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input int c, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cfg%0d: got %0d expected %0d", tag, c, obs, exp);
      end
   endtask

   task automatic model_step();
      longint top, s;
      for (int c = 0; c < 3; c++) begin
         m_sum[c] = 0;
         m_sv[c]  = 1'b0;
         if (rst) begin
            for (int k = 0; k < 4; k++) m_acc[c][k] = 0;
            m_dr[c]  = 1'b0;
            m_ptr[c] = 0;
            m_sat[c] = 1'b0;
         end else if (!m_dr[c]) begin
            if (in_valid && int'(in_idx) < cfg_n[c]) begin
               top = longint'(1) << cfg_aw[c];
               s   = in_first ? longint'(p_sum) : m_acc[c][in_idx] + longint'(p_sum);
               if (s >= top) begin
                  m_sat[c] = 1'b1;
                  s = cfg_sat[c] ? top - 1 : s - top;
               end
               m_acc[c][in_idx] = s;
               m_sum[c] = s;
               m_sv[c]  = 1'b1;
            end
            if (drain_req) begin
               m_dr[c]  = 1'b1;
               m_ptr[c] = 0;
            end
         end else if (out_ready) begin
            m_acc[c][m_ptr[c]] = 0;
            if (m_ptr[c] == cfg_n[c] - 1) begin
               m_dr[c]  = 1'b0;
               m_ptr[c] = 0;
               m_sat[c] = 1'b0;
            end else begin
               m_ptr[c]++;
            end
         end
      end
   endtask

   task automatic check_all();
      for (int c = 0; c < 3; c++) begin
         chk("in_ready", c, 32'(rdy[c]), 32'(!m_dr[c]));
         chk("drain_busy", c, 32'(busy[c]), 32'(m_dr[c]));
         chk("out_valid", c, 32'(ov[c]), 32'(m_dr[c]));
         chk("sum_valid", c, 32'(sv[c]), 32'(m_sv[c]));
         chk("sum_out", c, 32'(so[c]), 32'(m_sum[c]));
         chk("sat_flag", c, 32'(sat[c]), 32'(m_sat[c]));
         if (m_dr[c]) begin
            chk("out_idx", c, 32'(oidx[c]), 32'(m_ptr[c]));
            chk("out_data", c, 32'(od[c]), 32'(m_acc[c][m_ptr[c]]));
         end
      end
   endtask

   task automatic check_reset_vals();
      for (int c = 0; c < 3; c++) begin
         chk("rst_out_idx", c, 32'(oidx[c]), 32'd0);
         chk("rst_out_data", c, 32'(od[c]), 32'd0);
         chk("rst_in_ready", c, 32'(rdy[c]), 32'd1);
         chk("rst_out_valid", c, 32'(ov[c]), 32'd0);
         chk("rst_sum_out", c, 32'(so[c]), 32'd0);
      end
   endtask

   // One clock: inputs already applied, model follows the edge, outputs checked #1 later.
   task automatic cyc(input bit r, input bit v, input logic [1:0] idx, input bit f,
                      input logic [7:0] p, input bit dreq, input bit ordy);
      rst       = r;
      in_valid  = v;
      in_idx    = idx;
      in_first  = f;
      p_sum     = p;
      drain_req = dreq;
      out_ready = ordy;
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   initial begin
      bit ordy_seq [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      int n;

      // Reset
      cyc(1, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0);
      check_reset_vals();

      // Accumulate, back-to-back to the same index
      cyc(0, 1, 0, 1, 8'd10, 0, 0);
      chk("acc_10", 0, 32'(so0), 32'd10);
      cyc(0, 1, 0, 0, 8'd20, 0, 0);
      chk("acc_30", 0, 32'(so0), 32'd30);
      cyc(0, 1, 3, 1, 8'd255, 0, 0);
      chk("acc_255", 0, 32'(so0), 32'd255);
      cyc(0, 1, 3, 0, 8'd255, 0, 0);
      chk("acc_510", 0, 32'(so0), 32'd510);
      chk("acc_510_valid", 0, 32'(sv[0]), 32'd1);
      cyc(0, 0, 0, 0, 0, 0, 0);
      chk("idle_valid", 0, 32'(sv[0]), 32'd0);

      // Drain_req with a same-cycle input on acc[2]=7, then stall on idx 1
      cyc(0, 1, 2, 1, 8'd7, 0, 0);
      cyc(0, 1, 2, 0, 8'd5, 1, 0);
      for (int k = 0; k < 7; k++) begin
         if (m_dr[0] && m_ptr[0] == 2) chk("drain_idx2", 0, 32'(od0), 32'd12);
         cyc(0, (k < 6), 1, 0, 8'd3, 0, ordy_seq[k]);
      end
      chk("post_drain_ready", 0, 32'(rdy[0]), 32'd1);
      chk("post_drain_sat", 1, 32'(sat[1]), 32'd0);
      for (int k = 0; k < 4; k++) begin
         cyc(0, 1, 2'(k), 0, 8'd0, 0, 0);
         chk("cleared", 0, 32'(so0), 32'd0);
      end

      // Saturation vs wrap at ACC_W=8
      cyc(0, 1, 1, 1, 8'd200, 0, 0);
      cyc(0, 1, 1, 0, 8'd100, 0, 0);
      chk("sat_clamp", 1, 32'(so1), 32'd255);
      chk("sat_flag_clamp", 1, 32'(sat[1]), 32'd1);
      chk("sat_wrap", 2, 32'(so2), 32'd44);
      chk("sat_flag_wrap", 2, 32'(sat[2]), 32'd1);
      chk("no_sat_16", 0, 32'(so0), 32'd300);

      // Out-of-range index on NUM_ACC=3
      cyc(0, 1, 3, 0, 8'd9, 0, 0);
      chk("oor_valid", 2, 32'(sv[2]), 32'd0);
      chk("oor_sum", 2, 32'(so2), 32'd0);

      // Random traffic
      for (int k = 0; k < 400; k++) begin
         cyc(($urandom % 200) == 0, ($urandom % 4) != 0, 2'($urandom), ($urandom % 4) == 0,
             8'($urandom), ($urandom % 16) == 0, ($urandom % 4) != 0);
      end

      // Reset in mid-drain at ptr=2
      n = 0;
      while ((m_dr[0] || m_dr[1] || m_dr[2]) && n < 20) begin
         cyc(0, 0, 0, 0, 0, 0, 1);
         n++;
      end
      cyc(0, 1, 0, 1, 8'd50, 1, 1);
      n = 0;
      while (!(m_dr[0] && m_ptr[0] == 2) && n < 10) begin
         cyc(0, 0, 0, 0, 0, 0, 1);
         n++;
      end
      chk("reach_ptr2", 0, 32'(m_dr[0] && m_ptr[0] == 2), 32'd1);
      cyc(1, 0, 0, 0, 0, 0, 1);
      check_reset_vals();
      chk("rst_busy", 0, 32'(busy[0]), 32'd0);
      chk("rst_sat", 0, 32'(sat[0]), 32'd0);
      cyc(0, 1, 0, 0, 8'd4, 0, 0);
      chk("after_rst_4", 0, 32'(so0), 32'd4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
